// File: rtl/reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_wr_arbiter
// Description : Write-port controller for the register file. After reset it
//               zeroes registers 1..NREGS-1, then arbitrates two writeback
//               requesters (ALU = 0, load = 1) round-robin and issues one
//               registered write per cycle on Rw/RegWr/busW.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NREGS      = 32
) (
    input  logic                  Clock,
    input  logic                  sys_rst,

    input  logic                  valid0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  ready0,

    input  logic                  valid1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ready1,

    output logic [ADDR_WIDTH-1:0] Rw,
    output logic                  RegWr,
    output logic [DATA_WIDTH-1:0] busW,
    output logic                  init_done
);

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Highest register index; its sweep write is the last one before RUN.
    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NREGS - 1);

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  last;

    logic                  grant_valid;
    logic                  grant_sel;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // State register.
    always_ff @(posedge Clock) begin
        if (sys_rst) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next state: leave INIT once the final sweep address is being issued.
    always_comb begin
        next_state = state;
        case (state)
            INIT:    if (cnt == LAST_REG) next_state = RUN;
            RUN:     next_state = RUN;
            default: next_state = INIT;
        endcase
    end

    // Round-robin grant: on a tie the requester that did not win last time
    // is served; a lone requester is served immediately.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (state == RUN) begin
            if (valid0 && valid1) begin
                grant_valid = 1'b1;
                grant_sel   = ~last;
            end else if (valid0) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b0;
            end else if (valid1) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_addr = grant_sel ? addr1 : addr0;
        sel_data = grant_sel ? data1 : data0;
    end

    assign ready0    = grant_valid && !grant_sel;
    assign ready1    = grant_valid &&  grant_sel;
    assign init_done = (state == RUN);

    // Registered write port, sweep counter and round-robin history. Writes to
    // register 0 are still accepted (ready and last update) but never enabled.
    always_ff @(posedge Clock) begin
        if (sys_rst) begin
            cnt   <= ADDR_WIDTH'(1);
            Rw    <= '0;
            RegWr <= 1'b0;
            busW  <= '0;
            last  <= 1'b1;
        end else if (state == INIT) begin
            Rw    <= cnt;
            RegWr <= 1'b1;
            busW  <= '0;
            cnt   <= cnt + ADDR_WIDTH'(1);
        end else if (grant_valid) begin
            Rw    <= sel_addr;
            busW  <= sel_data;
            RegWr <= (sel_addr != '0);
            last  <= grant_sel;
        end else begin
            RegWr <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wr_arbiter
// Description : Self-checking bench for reg_wr_arbiter: directed scenarios
//               plus randomized requesters against a behavioural model of the
//               sweep, round-robin arbitration and resulting register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wr_arbiter;

    logic        Clock;
    logic        sys_rst;
    logic        valid0, valid1;
    logic [4:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic        ready0, ready1;
    logic [4:0]  Rw;
    logic        RegWr;
    logic [31:0] busW;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit          m_run;
    int          m_sweep;
    int          prefer;        // requester that wins the next tie
    logic [4:0]  m_rw;
    logic        m_wr;
    logic [31:0] m_bus;
    logic [31:0] rf_model [32];
    logic [31:0] dut_rf   [32];

    reg_wr_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .NREGS     (32)
    ) dut (
        .Clock    (Clock),
        .sys_rst  (sys_rst),
        .valid0   (valid0),
        .addr0    (addr0),
        .data0    (data0),
        .ready0   (ready0),
        .valid1   (valid1),
        .addr1    (addr1),
        .data1    (data1),
        .ready1   (ready1),
        .Rw       (Rw),
        .RegWr    (RegWr),
        .busW     (busW),
        .init_done(init_done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Register file fed by the DUT write port ($0 hardwired to zero).
    always @(posedge Clock) begin
        if (RegWr && Rw != 5'd0) dut_rf[Rw] <= busW;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_sweep = 1;
        prefer  = 0;
        m_rw    = 5'd0;
        m_wr    = 1'b0;
        m_bus   = 32'd0;
    endtask

    // One clock cycle: drive inputs, check grants, advance model, check outputs.
    task automatic step(input logic rst,
                        input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        output logic g0, output logic g1);
        logic e0, e1;
        @(negedge Clock);
        sys_rst = rst;
        valid0 = v0; addr0 = a0; data0 = d0;
        valid1 = v1; addr1 = a1; data1 = d1;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (m_run) begin
            if (v0 && v1) begin
                e0 = (prefer == 0);
                e1 = (prefer == 1);
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        chk("ready0", {31'd0, ready0}, {31'd0, e0});
        chk("ready1", {31'd0, ready1}, {31'd0, e1});
        g0 = e0;
        g1 = e1;

        if (rst) begin
            model_reset();
        end else if (!m_run) begin
            m_rw  = 5'(m_sweep);
            m_wr  = 1'b1;
            m_bus = 32'd0;
            rf_model[m_sweep] = 32'd0;
            if (m_sweep == 31) m_run = 1'b1;
            else m_sweep++;
        end else if (e0 || e1) begin
            m_rw   = e0 ? a0 : a1;
            m_bus  = e0 ? d0 : d1;
            m_wr   = (m_rw != 5'd0);
            if (m_wr) rf_model[m_rw] = m_bus;
            prefer = e0 ? 1 : 0;
        end else begin
            m_wr = 1'b0;
        end

        @(posedge Clock);
        #1;
        chk("RegWr",     {31'd0, RegWr},     {31'd0, m_wr});
        chk("Rw",        {27'd0, Rw},        {27'd0, m_rw});
        chk("busW",      busW,               m_bus);
        chk("init_done", {31'd0, init_done}, {31'd0, m_run});
    endtask

    task automatic idle(input logic rst);
        logic g0, g1;
        step(rst, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g0, g1);
    endtask

    initial begin
        logic        g0, g1;
        logic        p0, p1;
        logic [4:0]  pa0, pa1;
        logic [31:0] pd0, pd1;

        for (int i = 0; i < 32; i++) begin
            rf_model[i] = 32'd0;
            dut_rf[i]   = 32'd0;
        end
        sys_rst = 1'b1;
        valid0 = 1'b0; addr0 = '0; data0 = '0;
        valid1 = 1'b0; addr1 = '0; data1 = '0;
        repeat (3) @(posedge Clock);
        #1;
        model_reset();
        chk("rst_RegWr",     {31'd0, RegWr},     32'd0);
        chk("rst_Rw",        {27'd0, Rw},        32'd0);
        chk("rst_busW",      busW,               32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_ready0",    {31'd0, ready0},    32'd0);

        // Sweep with a pending request that must be held off until RUN.
        for (int i = 0; i < 31; i++)
            step(1'b0, 1'b1, 5'd1, 32'd20, 1'b0, 5'd0, 32'd0, g0, g1);
        chk("sweep_done", {31'd0, init_done}, 32'd1);

        // Single ALU write to $1.
        step(1'b0, 1'b1, 5'd1, 32'd20, 1'b0, 5'd0, 32'd0, g0, g1);
        idle(1'b0);
        idle(1'b0);
        chk("rf1_after_write", dut_rf[1], 32'd20);

        // Both requesters held for four cycles: alternating grants.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 5'd3, 32'd5, 1'b1, 5'd4, 32'd7, g0, g1);
        idle(1'b0);

        // Load write to $0: accepted but never written.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd99, g0, g1);
        idle(1'b0);
        idle(1'b0);
        chk("rf0_zero", dut_rf[0], 32'd0);

        // Randomized requesters that hold their request until accepted.
        p0 = 1'b0; p1 = 1'b0;
        pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && ($urandom_range(0, 2) != 0)) begin
                p0 = 1'b1; pa0 = 5'($urandom_range(0, 31)); pd0 = $urandom;
            end
            if (!p1 && ($urandom_range(0, 2) != 0)) begin
                p1 = 1'b1; pa1 = 5'($urandom_range(0, 31)); pd1 = $urandom;
            end
            step(($urandom_range(0, 99) == 0), p0, pa0, pd0, p1, pa1, pd1, g0, g1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
        end
        idle(1'b0);
        idle(1'b0);

        // Reset while the sweep is presenting Rw=10, then a full restart.
        idle(1'b1);
        for (int i = 0; i < 10; i++) idle(1'b0);
        chk("midsweep_Rw", {27'd0, Rw}, 32'd10);
        idle(1'b1);
        for (int i = 0; i < 31; i++) idle(1'b0);
        chk("resweep_done", {31'd0, init_done}, 32'd1);

        // Reset in the same cycle a request to $5 is accepted.
        step(1'b1, 1'b1, 5'd5, 32'd42, 1'b0, 5'd0, 32'd0, g0, g1);
        for (int i = 0; i < 33; i++) idle(1'b0);
        chk("rf5_not_42", dut_rf[5], 32'd0);

        // Final register file image against the model.
        for (int i = 0; i < 32; i++) chk("rf_final", dut_rf[i], rf_model[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
